// File: rtl/score_display_ctrl.sv
// score_display_ctrl: pong scoreboard sequencer.
// Owns both player scores, runs a frame-timed flash/enlarge animation on the
// scoring digit(s), and latches a game-over state until a new game is requested.
// Optional feature macro: SCORE_ATTRACT_PULSE_EN. When it is defined, the winning
// digit(s) pulse their scale in the game-over state. When it is not defined, the
// winning digit(s) hold a static enlarged size.
module score_display_ctrl #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned BASE_SCALE   = 3,
  parameter int unsigned BIG_SCALE    = 4,
  parameter int unsigned FLASH_FRAMES = 60,
  parameter int unsigned FLASH_PERIOD = 8,
  parameter logic [7:0]  FG_COLOR     = 8'hFF,
  parameter logic [7:0]  FLASH_COLOR  = 8'hE0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       point_left,
  input  logic       point_right,
  input  logic       clear,
  output logic [3:0] left_value,
  output logic [3:0] right_value,
  output logic [3:0] left_scale,
  output logic [3:0] right_scale,
  output logic [7:0] left_color,
  output logic [7:0] right_color,
  output logic       busy,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int unsigned CW = $clog2(FLASH_FRAMES + 1);

  localparam logic [1:0] ST_PLAY  = 2'd0;
  localparam logic [1:0] ST_FLASH = 2'd1;
  localparam logic [1:0] ST_OVER  = 2'd2;

  localparam logic [3:0]    BASE_C   = 4'(BASE_SCALE);
  localparam logic [3:0]    BIG_C    = 4'(BIG_SCALE);
  localparam logic [3:0]    WIN_C    = 4'(WIN_SCORE);
  localparam logic [CW-1:0] FRAMES_C = CW'(FLASH_FRAMES);

`ifdef SCORE_ATTRACT_PULSE_EN
  localparam int unsigned PW    = $clog2(FLASH_PERIOD + 1);
  localparam logic [PW-1:0] PER_C = PW'(FLASH_PERIOD);
  logic [PW-1:0] pcnt_q, pcnt_d, pcnt_inc;
`endif

  // Game state
  logic [1:0]    state_q, state_d;
  logic [3:0]    left_q, left_d;
  logic [3:0]    right_q, right_d;
  logic [1:0]    mask_q, mask_d;      // bit0 = left digit, bit1 = right digit
  logic          phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  // Registered display outputs
  logic [3:0] left_scale_q, left_scale_d, right_scale_q, right_scale_d;
  logic [7:0] left_color_q, left_color_d, right_color_q, right_color_d;
  logic       busy_q, busy_d, game_over_q, game_over_d;
  logic [1:0] winner_q, winner_d;
  logic       left_win_d, right_win_d;
  logic [11:0] left_style_d, right_style_d;

  // Score increment that saturates at the largest displayable digit
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    logic [3:0] r;
    if (v >= 4'd9) begin
      r = 4'd9;
    end else begin
      r = v + 4'd1;
    end
    return r;
  endfunction

  // Scale/colour of one digit for a given state, as {scale, colour}
  function automatic logic [11:0] digit_style(input logic [1:0] st, input logic masked,
                                              input logic won, input logic ph);
    logic [11:0] s;
    s = {BASE_C, FG_COLOR};
    case (st)
      ST_FLASH: begin
        if (masked) begin
          s = {BIG_C, (ph ? FLASH_COLOR : FG_COLOR)};
        end else begin
          s = {BASE_C, FG_COLOR};
        end
      end
      ST_OVER: begin
        if (won) begin
`ifdef SCORE_ATTRACT_PULSE_EN
          s = {(ph ? BIG_C : BASE_C), FLASH_COLOR};
`else
          s = {BIG_C, FLASH_COLOR};
`endif
        end else begin
          s = {BASE_C, FG_COLOR};
        end
      end
      default: s = {BASE_C, FG_COLOR};
    endcase
    return s;
  endfunction

  // Next-state logic: scoring, animation timing and win resolution
  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    right_d = right_q;
    mask_d  = mask_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + {{(CW-1){1'b0}}, 1'b1};
`ifdef SCORE_ATTRACT_PULSE_EN
    pcnt_d   = pcnt_q;
    pcnt_inc = pcnt_q + {{(PW-1){1'b0}}, 1'b1};
`endif
    if (clear) begin
      state_d = ST_PLAY;
      left_d  = 4'd0;
      right_d = 4'd0;
      mask_d  = 2'b00;
      phase_d = 1'b0;
      cnt_d   = {CW{1'b0}};
`ifdef SCORE_ATTRACT_PULSE_EN
      pcnt_d  = {PW{1'b0}};
`endif
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (point_left || point_right) begin
            if (point_left) begin
              left_d = sat_inc(left_q);
            end else begin
              left_d = left_q;
            end
            if (point_right) begin
              right_d = sat_inc(right_q);
            end else begin
              right_d = right_q;
            end
            mask_d  = {point_right, point_left};
            cnt_d   = {CW{1'b0}};
            phase_d = 1'b1;
            state_d = ST_FLASH;
          end else begin
            state_d = ST_PLAY;
          end
        end
        ST_FLASH: begin
          // Point pulses are dropped while animating
          if (frame_tick) begin
            cnt_d = cnt_inc;
            if ((32'(cnt_inc) % FLASH_PERIOD) == 32'd0) begin
              phase_d = ~phase_q;
            end else begin
              phase_d = phase_q;
            end
            if (cnt_inc == FRAMES_C) begin
              mask_d = 2'b00;
              cnt_d  = {CW{1'b0}};
              if ((left_q >= WIN_C) || (right_q >= WIN_C)) begin
                state_d = ST_OVER;
                phase_d = 1'b1;   // attract pulse starts enlarged
`ifdef SCORE_ATTRACT_PULSE_EN
                pcnt_d  = {PW{1'b0}};
`endif
              end else begin
                state_d = ST_PLAY;
                phase_d = 1'b0;
              end
            end else begin
              state_d = ST_FLASH;
            end
          end else begin
            state_d = ST_FLASH;
          end
        end
        ST_OVER: begin
          state_d = ST_OVER;
`ifdef SCORE_ATTRACT_PULSE_EN
          if (frame_tick) begin
            if (pcnt_inc == PER_C) begin
              pcnt_d  = {PW{1'b0}};
              phase_d = ~phase_q;
            end else begin
              pcnt_d  = pcnt_inc;
            end
          end else begin
            pcnt_d = pcnt_q;
          end
`endif
        end
        default: begin
          state_d = ST_PLAY;
          mask_d  = 2'b00;
          phase_d = 1'b0;
          cnt_d   = {CW{1'b0}};
        end
      endcase
    end
  end

  // Output decode from next-state values so every output is a register
  always_comb begin
    left_win_d    = (left_d >= WIN_C);
    right_win_d   = (right_d >= WIN_C);
    left_style_d  = digit_style(state_d, mask_d[0], left_win_d, phase_d);
    right_style_d = digit_style(state_d, mask_d[1], right_win_d, phase_d);
    left_scale_d  = left_style_d[11:8];
    left_color_d  = left_style_d[7:0];
    right_scale_d = right_style_d[11:8];
    right_color_d = right_style_d[7:0];
    busy_d        = (state_d == ST_FLASH);
    game_over_d   = (state_d == ST_OVER);
    if (state_d == ST_OVER) begin
      winner_d = {right_win_d, left_win_d};
    end else begin
      winner_d = 2'b00;
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_PLAY;
      left_q        <= 4'd0;
      right_q       <= 4'd0;
      mask_q        <= 2'b00;
      phase_q       <= 1'b0;
      cnt_q         <= {CW{1'b0}};
`ifdef SCORE_ATTRACT_PULSE_EN
      pcnt_q        <= {PW{1'b0}};
`endif
      left_scale_q  <= BASE_C;
      right_scale_q <= BASE_C;
      left_color_q  <= FG_COLOR;
      right_color_q <= FG_COLOR;
      busy_q        <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      left_q        <= left_d;
      right_q       <= right_d;
      mask_q        <= mask_d;
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
`ifdef SCORE_ATTRACT_PULSE_EN
      pcnt_q        <= pcnt_d;
`endif
      left_scale_q  <= left_scale_d;
      right_scale_q <= right_scale_d;
      left_color_q  <= left_color_d;
      right_color_q <= right_color_d;
      busy_q        <= busy_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
    end
  end

  assign left_value  = left_q;
  assign right_value = right_q;
  assign left_scale  = left_scale_q;
  assign right_scale = right_scale_q;
  assign left_color  = left_color_q;
  assign right_color = right_color_q;
  assign busy        = busy_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl with a behavioural scoreboard model.
module tb_score_display_ctrl;

  localparam int WIN = 9;
  localparam int FF  = 5;
  localparam int FP  = 2;

  logic       clk, reset, frame_tick, point_left, point_right, clear;
  logic [3:0] left_value, right_value, left_scale, right_scale;
  logic [7:0] left_color, right_color;
  logic       busy, game_over;
  logic [1:0] winner;

  int n_vec = 0;
  int n_err = 0;

  // Model: scores, mode (0 play, 1 flash, 2 over), ticks elapsed, flash mask
  int m_score[2];
  int m_mode;
  int m_frames;
  int m_over;
  bit m_mask[2];

  score_display_ctrl #(
    .WIN_SCORE(WIN), .BASE_SCALE(3), .BIG_SCALE(4), .FLASH_FRAMES(FF),
    .FLASH_PERIOD(FP), .FG_COLOR(8'hFF), .FLASH_COLOR(8'hE0)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .point_left(point_left),
    .point_right(point_right), .clear(clear), .left_value(left_value),
    .right_value(right_value), .left_scale(left_scale), .right_scale(right_scale),
    .left_color(left_color), .right_color(right_color), .busy(busy),
    .game_over(game_over), .winner(winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_score[0] = 0; m_score[1] = 0;
    m_mode = 0; m_frames = 0; m_over = 0;
    m_mask[0] = 1'b0; m_mask[1] = 1'b0;
  endtask

  task automatic model_edge(input bit pl, input bit pr, input bit ft, input bit clr);
    if (clr) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (pl || pr) begin
        if (pl && m_score[0] < 9) m_score[0]++;
        if (pr && m_score[1] < 9) m_score[1]++;
        m_mask[0] = pl; m_mask[1] = pr;
        m_frames = 0;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (ft) begin
        m_frames++;
        if (m_frames == FF) begin
          m_mask[0] = 1'b0; m_mask[1] = 1'b0;
          m_over = 0;
          m_mode = (m_score[0] >= WIN || m_score[1] >= WIN) ? 2 : 0;
        end
      end
    end else begin
      if (ft) m_over++;
    end
  endtask

  // Expected {scale, colour} of one digit; phase = toggled once per FP ticks from 1
  function automatic logic [11:0] exp_style(input int s);
    bit won;
    won = (m_score[s] >= WIN);
    if (m_mode == 1 && m_mask[s])
      return {4'd4, (((m_frames / FP) % 2) == 0) ? 8'hE0 : 8'hFF};
    if (m_mode == 2 && won)
`ifdef SCORE_ATTRACT_PULSE_EN
      return {(((m_over / FP) % 2) == 0) ? 4'd4 : 4'd3, 8'hE0};
`else
      return {4'd4, 8'hE0};
`endif
    return {4'd3, 8'hFF};
  endfunction

  task automatic check_all();
    logic [11:0] ls, rs;
    logic [1:0]  w;
    ls = exp_style(0);
    rs = exp_style(1);
    w  = (m_mode == 2) ? {(m_score[1] >= WIN), (m_score[0] >= WIN)} : 2'b00;
    chk("left_value",  32'(left_value),  32'(m_score[0]));
    chk("right_value", 32'(right_value), 32'(m_score[1]));
    chk("left_scale",  32'(left_scale),  32'(ls[11:8]));
    chk("left_color",  32'(left_color),  32'(ls[7:0]));
    chk("right_scale", 32'(right_scale), 32'(rs[11:8]));
    chk("right_color", 32'(right_color), 32'(rs[7:0]));
    chk("busy",        32'(busy),        32'(m_mode == 1));
    chk("game_over",   32'(game_over),   32'(m_mode == 2));
    chk("winner",      32'(winner),      32'(w));
  endtask

  // One clock: drive inputs, take the edge, advance the model, then compare
  task automatic cycle(input bit pl, input bit pr, input bit ft, input bit clr);
    point_left = pl; point_right = pr; frame_tick = ft; clear = clr;
    @(posedge clk);
    model_edge(pl, pr, ft, clr);
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b0; frame_tick = 1'b0; point_left = 1'b0; point_right = 1'b0; clear = 1'b0;
    model_reset();
    #12;
    check_all();
    chk("rst_left_scale", 32'(left_scale), 32'd3);
    chk("rst_right_color", 32'(right_color), 32'hFF);
    @(negedge clk);
    reset = 1'b1;

    // Frame ticks while idle change nothing
    repeat (100) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("idle_left_value", 32'(left_value), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single left point, ticks interleaved with idle cycles
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pt_left_value", 32'(left_value), 32'd1);
    chk("pt_left_scale", 32'(left_scale), 32'd4);
    chk("pt_left_color", 32'(left_color), 32'hE0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("tick2_color", 32'(left_color), 32'hFF);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("tick4_color", 32'(left_color), 32'hE0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("end_scale", 32'(left_scale), 32'd3);
    chk("end_color", 32'(left_color), 32'hFF);
    chk("end_busy", 32'(busy), 32'd0);

    // Both sides score together
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("both_left", 32'(left_value), 32'd2);
    chk("both_right", 32'(right_value), 32'd1);
    chk("both_rscale", 32'(right_scale), 32'd4);
    repeat (5) cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Points during flash, including on the final tick, are dropped
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("drop_right", 32'(right_value), 32'd2);
    chk("drop_busy", 32'(busy), 32'd0);

    // Left climbs to the winning score
    repeat (7) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (5) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("win_left", 32'(left_value), 32'd9);
    chk("win_over", 32'(game_over), 32'd1);
    chk("win_winner", 32'(winner), 32'd1);
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b0);
    chk("over_right", 32'(right_value), 32'd2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_left", 32'(left_value), 32'd0);
    chk("clr_over", 32'(game_over), 32'd0);

    // Clear beats a coincident point
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clrpri_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of an animation
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("arst_rvalue", 32'(right_value), 32'd0);
    chk("arst_rscale", 32'(right_scale), 32'd3);
    #3;
    reset = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Simultaneous win
    repeat (9) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (5) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("tie_winner", 32'(winner), 32'd3);
    chk("tie_rcolor", 32'(right_color), 32'hE0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("tie_clr", 32'(winner), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
